hdma_xfer: RTL and testbench

// - Byte mover directly downstream of the GBC HDMA/GDMA address sequencer.
// - Consumes hdma_rd and the source/target addresses, reads each source byte over the CPU bus and writes it into VRAM.
// - Holds the CPU off the bus (cpu_stall) for the whole transfer plus a short tail.
// - Sits between the sequencer, the cart/WRAM bus mux and the VRAM port.

---
 rtl/hdma_xfer_if.sv | 48 ++++
 rtl/hdma_xfer.sv | 140 ++++++++++++++
 tb/tb_hdma_xfer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdma_xfer_if.sv
// HDMA byte-mover bus bundle: sequencer inputs, CPU bus read side, VRAM write port.
// slave modport is the mover itself; master is whoever drives it.
interface hdma_xfer_if #(
    parameter int VRAM_AW = 13
);
    logic               hdma_rd;
    logic [15:0]        hdma_source_addr;
    logic [15:0]        hdma_target_addr;
    logic               vram_bank;
    logic [7:0]         bus_din;
    logic [15:0]        bus_addr;
    logic               bus_rd;
    logic [VRAM_AW:0]   vram_addr;
    logic               vram_we;
    logic [7:0]         vram_dout;
    logic               cpu_stall;
    logic [11:0]        byte_cnt;

    modport slave (
        input  hdma_rd,
        input  hdma_source_addr,
        input  hdma_target_addr,
        input  vram_bank,
        input  bus_din,
        output bus_addr,
        output bus_rd,
        output vram_addr,
        output vram_we,
        output vram_dout,
        output cpu_stall,
        output byte_cnt
    );

    modport master (
        output hdma_rd,
        output hdma_source_addr,
        output hdma_target_addr,
        output vram_bank,
        output bus_din,
        input  bus_addr,
        input  bus_rd,
        input  vram_addr,
        input  vram_we,
        input  vram_dout,
        input  cpu_stall,
        input  byte_cnt
    );
endinterface

// File: rtl/hdma_xfer.sv
// GBC HDMA/GDMA byte mover: reads source bytes on the CPU bus, writes them to VRAM.
// Optional HDMA_XFER_SRC_GUARD_EN: VRAM/echo-high sources read back as 0xFF, no bus read.
module hdma_xfer #(
    parameter int VRAM_AW    = 13,
    parameter int STALL_TAIL = 1
) (
    input  logic         clk,
    input  logic         reset,
    hdma_xfer_if.slave   bus
);
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

    phase_t             r_phase;
    phase_t             w_phase_nxt;
    logic               w_issue;
    logic               w_cap;
    logic               r_rd_q;
    logic               w_rise;
    logic [15:0]        r_bus_addr;
    logic [VRAM_AW:0]   r_tgt;
    logic [VRAM_AW:0]   r_tgt_q;
    logic [7:0]         r_buf;
    logic               r_pend;
    logic [1:0]         r_tail;
    logic [11:0]        r_byte_cnt;
    logic               w_blk;
    logic [7:0]         w_rd_data;
    logic               w_unused;

    assign w_unused = &{1'b0, bus.hdma_target_addr[15:VRAM_AW]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_ADDR;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    // Phase only advances while the sequencer holds hdma_rd.
    always_comb begin
        w_phase_nxt = PH_ADDR;
        w_issue     = 1'b0;
        w_cap       = 1'b0;
        if (bus.hdma_rd) begin
            unique case (r_phase)
                PH_ADDR: begin
                    w_phase_nxt = PH_DATA;
                    w_issue     = 1'b1;
                end
                PH_DATA: begin
                    w_phase_nxt = PH_ADDR;
                    w_cap       = 1'b1;
                end
                default: begin
                    w_phase_nxt = PH_ADDR;
                end
            endcase
        end
    end

`ifdef HDMA_XFER_SRC_GUARD_EN
    logic r_blk;

    assign w_blk = (bus.hdma_source_addr[15:13] == 3'b100) ||
                   (bus.hdma_source_addr[15:13] == 3'b111);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk <= 1'b0;
        end else if (w_issue) begin
            r_blk <= w_blk;
        end
    end

    assign w_rd_data = r_blk ? 8'hFF : bus.bus_din;
`else
    assign w_blk     = 1'b0;
    assign w_rd_data = bus.bus_din;
`endif

    assign w_rise = bus.hdma_rd & ~r_rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_q     <= 1'b0;
            r_bus_addr <= '0;
            r_tgt      <= '0;
            r_tgt_q    <= '0;
            r_buf      <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_rd_q <= bus.hdma_rd;
            if (w_issue) begin
                r_bus_addr <= bus.hdma_source_addr;
                r_tgt      <= {bus.vram_bank,
                               bus.hdma_target_addr[VRAM_AW-1:0]};
            end
            // tgt_q is separate so the next byte's latch cannot clobber it.
            if (w_cap) begin
                r_tgt_q <= r_tgt;
                r_buf   <= w_rd_data;
            end
            r_pend <= w_cap;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_cnt <= '0;
        end else if (w_rise) begin
            r_byte_cnt <= '0;
        end else if (r_pend) begin
            r_byte_cnt <= r_byte_cnt + 12'd1;
        end
    end

    // Tail keeps the CPU off the bus a few clocks past the final write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tail <= '0;
        end else if (r_pend && !bus.hdma_rd) begin
            r_tail <= 2'(STALL_TAIL);
        end else if (r_tail != 2'd0) begin
            r_tail <= r_tail - 2'd1;
        end
    end

    assign bus.bus_rd    = w_issue & ~w_blk & ~reset;
    assign bus.bus_addr  = (w_issue && !reset) ? bus.hdma_source_addr
                                               : r_bus_addr;
    assign bus.vram_we   = r_pend & ~reset;
    assign bus.vram_addr = r_tgt_q;
    assign bus.vram_dout = r_buf;
    assign bus.cpu_stall = (bus.hdma_rd | r_pend | (r_tail != 2'd0)) & ~reset;
    assign bus.byte_cnt  = r_byte_cnt;
endmodule

// File: tb/tb_hdma_xfer.sv
// Directed bench for hdma_xfer: per-cycle vector table plus multi-byte sequences.
// Expectations track the HDMA_XFER_SRC_GUARD_EN build option.
module tb_hdma_xfer;
    localparam int STALL_TAIL = 1;
`ifdef HDMA_XFER_SRC_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        rd;
        logic [15:0] src;
        logic [15:0] tgt;
        logic        bank;
        logic [7:0]  din;
        logic        e_brd;
        logic [15:0] e_baddr;
        logic        e_we;
        logic [13:0] e_vaddr;
        logic [7:0]  e_vdout;
        logic        e_stall;
        logic [11:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    hdma_xfer_if #(.VRAM_AW(13)) bif();

    hdma_xfer #(
        .VRAM_AW   (13),
        .STALL_TAIL(STALL_TAIL)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int          wcyc[$];
    logic [13:0] waddr[$];
    logic [7:0]  wdat[$];
    int          last_stall = 0;
    bit          saw_rd = 0;

    always @(negedge clk) begin
        if (bif.vram_we === 1'b1) begin
            wcyc.push_back(cyc);
            waddr.push_back(bif.vram_addr);
            wdat.push_back(bif.vram_dout);
        end
        if (bif.cpu_stall === 1'b1) last_stall = cyc;
        if (bif.bus_rd === 1'b1) saw_rd = 1'b1;
    end

    function automatic vec_t mk(
        input logic rst, input logic rd, input logic [15:0] src,
        input logic [15:0] tgt, input logic bank, input logic [7:0] din,
        input logic brd, input logic [15:0] baddr, input logic we,
        input logic [13:0] vaddr, input logic [7:0] vdout,
        input logic stall, input logic [11:0] cnt);
        vec_t v;
        v.rst = rst; v.rd = rd; v.src = src; v.tgt = tgt;
        v.bank = bank; v.din = din; v.e_brd = brd; v.e_baddr = baddr;
        v.e_we = we; v.e_vaddr = vaddr; v.e_vdout = vdout;
        v.e_stall = stall; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wcyc.delete();
        waddr.delete();
        wdat.delete();
        saw_rd = 1'b0;
    endtask

    task automatic byte_cycles(input logic [15:0] s, input logic [15:0] t,
                               input logic b);
        bif.hdma_rd = 1'b1;
        bif.hdma_source_addr = s;
        bif.hdma_target_addr = t;
        bif.vram_bank = b;
        bif.bus_din = 8'h00;
        step();
        bif.bus_din = s[7:0];
        step();
    endtask

    // Leaves hdma_rd low in the current cycle on return.
    task automatic run_block(input logic [15:0] s, input logic [15:0] t,
                             input logic b, input int n, input int drop,
                             output int rise);
        rise = cyc;
        for (int i = 0; i < n; i++) begin
            if (i == drop) break;
            byte_cycles(s + 16'(i), t + 16'(i), b);
        end
        bif.hdma_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_block(input string nm, input int rise,
                               input int nexp, input logic [13:0] a0,
                               input logic [7:0] d0, input bit gsrc);
        logic [7:0] ed;
        chk({nm, " writes"}, wcyc.size(), nexp);
        for (int i = 0; i < wcyc.size() && i < nexp; i++) begin
            ed = (gsrc && GUARD) ? 8'hFF : d0 + 8'(i);
            chk({nm, " we_cycle"}, wcyc[i], rise + 2 + 2 * i);
            chk({nm, " vram_addr"}, waddr[i], a0 + 14'(i));
            chk({nm, " vram_dout"}, wdat[i], ed);
        end
        chk({nm, " byte_cnt"}, bif.byte_cnt, nexp);
        if (wcyc.size() > 0)
            chk({nm, " stall_end"}, last_stall + 1,
                wcyc[wcyc.size() - 1] + 1 + STALL_TAIL);
    endtask

    vec_t tbl[16];

    initial begin
        logic [7:0] d10;
        int r1;
        int r2;
        bit dup;
        d10 = GUARD ? 8'hFF : 8'h5A;
        tbl[0]  = mk(1, 0, 'h0000, 'h0000, 0, 'h00, 0, 'h0000, 0, 'h0000, 'h00, 0, 0);
        tbl[1]  = mk(0, 1, 'h2040, 'h8200, 0, 'h00, 1, 'h2040, 0, 'h0000, 'h00, 1, 0);
        tbl[2]  = mk(0, 1, 'h2040, 'h8200, 0, 'h40, 0, 'h2040, 0, 'h0000, 'h00, 1, 0);
        tbl[3]  = mk(0, 1, 'h2041, 'h8201, 0, 'h00, 1, 'h2041, 1, 'h0200, 'h40, 1, 0);
        tbl[4]  = mk(0, 1, 'h2041, 'h8201, 0, 'h41, 0, 'h2041, 0, 'h0200, 'h40, 1, 1);
        tbl[5]  = mk(0, 0, 'h2041, 'h8201, 0, 'h00, 0, 'h2041, 1, 'h0201, 'h41, 1, 1);
        tbl[6]  = mk(0, 0, 'h2041, 'h8201, 0, 'h00, 0, 'h2041, 0, 'h0201, 'h41, 1, 2);
        tbl[7]  = mk(0, 0, 'h2041, 'h8201, 0, 'h00, 0, 'h2041, 0, 'h0201, 'h41, 0, 2);
        tbl[8]  = mk(0, 1, 'hE000, 'h9FFF, 1, 'h00, !GUARD, 'hE000, 0, 'h0201, 'h41, 1, 2);
        tbl[9]  = mk(0, 1, 'hE000, 'h9FFF, 1, 'h5A, 0, 'hE000, 0, 'h0201, 'h41, 1, 0);
        tbl[10] = mk(0, 0, 'hE000, 'h9FFF, 1, 'h00, 0, 'hE000, 1, 'h3FFF, d10, 1, 0);
        tbl[11] = mk(0, 0, 'hE000, 'h9FFF, 1, 'h00, 0, 'hE000, 0, 'h3FFF, d10, 1, 1);
        tbl[12] = mk(0, 0, 'hE000, 'h9FFF, 1, 'h00, 0, 'hE000, 0, 'h3FFF, d10, 0, 1);
        tbl[13] = mk(0, 1, 'h1000, 'h8000, 0, 'h00, 1, 'h1000, 0, 'h3FFF, d10, 1, 1);
        tbl[14] = mk(0, 0, 'h1000, 'h8000, 0, 'h00, 0, 'h1000, 0, 'h3FFF, d10, 0, 0);
        tbl[15] = mk(0, 0, 'h1000, 'h8000, 0, 'h00, 0, 'h1000, 0, 'h3FFF, d10, 0, 0);

        reset = 1'b1;
        bif.hdma_rd = 1'b0;
        bif.hdma_source_addr = '0;
        bif.hdma_target_addr = '0;
        bif.vram_bank = 1'b0;
        bif.bus_din = '0;
        step();

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst;
            bif.hdma_rd = tbl[i].rd;
            bif.hdma_source_addr = tbl[i].src;
            bif.hdma_target_addr = tbl[i].tgt;
            bif.vram_bank = tbl[i].bank;
            bif.bus_din = tbl[i].din;
            @(negedge clk);
            chk($sformatf("v%0d bus_rd", i), bif.bus_rd, tbl[i].e_brd);
            chk($sformatf("v%0d bus_addr", i), bif.bus_addr, tbl[i].e_baddr);
            chk($sformatf("v%0d vram_we", i), bif.vram_we, tbl[i].e_we);
            chk($sformatf("v%0d vram_addr", i), bif.vram_addr, tbl[i].e_vaddr);
            chk($sformatf("v%0d vram_dout", i), bif.vram_dout, tbl[i].e_vdout);
            chk($sformatf("v%0d cpu_stall", i), bif.cpu_stall, tbl[i].e_stall);
            chk($sformatf("v%0d byte_cnt", i), bif.byte_cnt, tbl[i].e_cnt);
            step();
        end

        clr();
        run_block(16'h2040, 16'h8200, 1'b0, 32, -1, r1);
        idle(6);
        check_block("gdma32", r1, 32, 14'h0200, 8'h40, 1'b0);

        clr();
        run_block(16'h3000, 16'h8200, 1'b1, 16, -1, r1);
        idle(6);
        check_block("bank1", r1, 16, 14'h2200, 8'h00, 1'b0);

        clr();
        run_block(16'h3100, 16'h8300, 1'b0, 8, 4, r1);
        idle(6);
        check_block("cancel", r1, 4, 14'h0300, 8'h00, 1'b0);

        clr();
        run_block(16'h4000, 16'h8000, 1'b0, 16, -1, r1);
        step();
        run_block(16'h4010, 16'h8010, 1'b0, 16, -1, r2);
        idle(6);
        chk("b2b writes", wcyc.size(), 32);
        dup = 1'b0;
        for (int i = 0; i < wcyc.size(); i++)
            for (int j = i + 1; j < wcyc.size(); j++)
                if (waddr[i] == waddr[j]) dup = 1'b1;
        chk("b2b no_dup", dup, 1'b0);
        if (wcyc.size() == 32) begin
            chk("b2b blk1_last_cyc", wcyc[15], r1 + 32);
            chk("b2b blk1_last_addr", waddr[15], 14'h000F);
            chk("b2b blk2_first_cyc", wcyc[16], r2 + 2);
            chk("b2b blk2_last_data", wdat[31], 8'h1F);
        end
        chk("b2b byte_cnt", bif.byte_cnt, 16);

        clr();
        byte_cycles(16'h5000, 16'h8100, 1'b0);
        byte_cycles(16'h5001, 16'h8101, 1'b0);
        bif.hdma_source_addr = 16'h5002;
        bif.hdma_target_addr = 16'h8102;
        step();
        reset = 1'b1;
        bif.bus_din = 8'h02;
        @(negedge clk);
        chk("rst cnt_before", bif.byte_cnt, 2);
        step();
        reset = 1'b0;
        bif.hdma_rd = 1'b0;
        @(negedge clk);
        chk("rst bus_rd", bif.bus_rd, 1'b0);
        chk("rst bus_addr", bif.bus_addr, 16'h0000);
        chk("rst vram_we", bif.vram_we, 1'b0);
        chk("rst vram_addr", bif.vram_addr, 14'h0000);
        chk("rst vram_dout", bif.vram_dout, 8'h00);
        chk("rst cpu_stall", bif.cpu_stall, 1'b0);
        chk("rst byte_cnt", bif.byte_cnt, 12'h000);
        idle(4);
        chk("rst writes", wcyc.size(), 2);

        clr();
        run_block(16'hE000, 16'h8000, 1'b0, 4, -1, r1);
        idle(6);
        check_block("guard", r1, 4, 14'h0000, 8'h00, 1'b1);
        chk("guard bus_rd_seen", saw_rd, !GUARD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
